yasac_host_arbiter: RTL and testbench

- Sequencer/arbiter that shares one YASAC processor between two host requesters.
- Round-robin grant; latches the winner's operand and drives the processor's start/data_in.
- Waits for completion via ready, captures data_out, returns it with a one-cycle ack.
- Watchdog recovers a hung processor via a dedicated processor reset pulse. Sits between host logic and the yasac top.

---
 rtl/yasac_host_arbiter_if.sv | 38 +++
 rtl/yasac_host_arbiter.sv | 128 ++++++++++++
 tb/tb_yasac_host_arbiter.sv | 239 +++++++++++++++++++++++
 3 files changed

// File: rtl/yasac_host_arbiter_if.sv
// yasac_host_arbiter_if
//   Bundles the host-side request/ack signals and the processor-side
//   start/ready/data signals of the YASAC host arbiter.
//   master : the arbiter view (drives acks, result, processor controls)
//   slave  : the environment view (drives requests and processor responses)
//
//   Host side      : req0/din0, req1/din1 -> ack0/ack1, dout, err, busy
//   Processor side : cpu_start, cpu_data_in, cpu_reset -> cpu_ready, cpu_data_out
//   Debug          : state_out (FSM state encoding)
interface yasac_host_arbiter_if;
  logic       req0;
  logic [7:0] din0;
  logic       req1;
  logic [7:0] din1;
  logic       ack0;
  logic       ack1;
  logic [7:0] dout;
  logic       err;
  logic       busy;
  logic       cpu_start;
  logic [7:0] cpu_data_in;
  logic       cpu_reset;
  logic       cpu_ready;
  logic [7:0] cpu_data_out;
  logic [2:0] state_out;

  modport master (
    input  req0, din0, req1, din1, cpu_ready, cpu_data_out,
    output ack0, ack1, dout, err, busy, cpu_start, cpu_data_in, cpu_reset,
           state_out
  );

  modport slave (
    output req0, din0, req1, din1, cpu_ready, cpu_data_out,
    input  ack0, ack1, dout, err, busy, cpu_start, cpu_data_in, cpu_reset,
           state_out
  );
endinterface

// File: rtl/yasac_host_arbiter.sv
// yasac_host_arbiter
//   Shares one YASAC processor between two host requesters. Grants
//   round-robin, launches the processor with the winner's operand, waits for
//   completion and returns the result with a one-cycle ack. A watchdog
//   pulses cpu_reset when the processor hangs and reports err=1 with
//   dout=0x00.
//
//   Parameters : TIMEOUT (1..255) cycles from start to fault,
//                CNT_W watchdog counter width
//   Ports      : clk, reset (async, active-high), bus (master modport of
//                yasac_host_arbiter_if)
module yasac_host_arbiter #(
  parameter int unsigned TIMEOUT = 255,
  parameter int unsigned CNT_W   = 8
) (
  input  logic                clk,
  input  logic                reset,
  yasac_host_arbiter_if.master bus
);

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    LAUNCH   = 3'd1,
    WAIT_LOW = 3'd2,
    RUN      = 3'd3,
    DONE     = 3'd4,
    RECOVER  = 3'd5
  } state_t;

  state_t             state_q;
  logic               grant_q;      // 0 = requester 0, 1 = requester 1
  logic               ptr_q;        // last-granted requester
  logic               rec_first_q;  // first cycle of RECOVER
  logic [CNT_W-1:0]   cnt_q;
  logic [7:0]         data_in_q;
  logic [7:0]         dout_q;
  logic               err_q;

  logic               win1_d;
  logic               timeout_hit;
  logic [CNT_W-1:0]   cnt_d;

  // With both requesting, the requester that did not win last time goes.
  assign win1_d = bus.req1 & (~bus.req0 | ~ptr_q);

  // The counter holds k-1 in the k-th cycle after start; the fault is taken
  // on the cycle it would become TIMEOUT-1, so cpu_reset appears TIMEOUT
  // cycles after the start pulse. Small TIMEOUT values trip immediately.
  assign cnt_d       = cnt_q + CNT_W'(1);
  assign timeout_hit = ({1'b0, cnt_q} + (CNT_W+1)'(2)) >= (CNT_W+1)'(TIMEOUT);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      grant_q     <= 1'b0;
      ptr_q       <= 1'b1;
      rec_first_q <= 1'b0;
      cnt_q       <= '0;
      data_in_q   <= 8'h00;
      dout_q      <= 8'h00;
      err_q       <= 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (bus.cpu_ready && (bus.req0 || bus.req1)) begin
            grant_q   <= win1_d;
            ptr_q     <= win1_d;
            data_in_q <= win1_d ? bus.din1 : bus.din0;
            state_q   <= LAUNCH;
          end
        end
        LAUNCH: begin
          cnt_q   <= '0;
          state_q <= WAIT_LOW;
        end
        WAIT_LOW: begin
          cnt_q <= cnt_d;
          if (!bus.cpu_ready) begin
            state_q <= RUN;
          end else if (timeout_hit) begin
            dout_q      <= 8'h00;
            err_q       <= 1'b1;
            rec_first_q <= 1'b1;
            state_q     <= RECOVER;
          end
        end
        RUN: begin
          cnt_q <= cnt_d;
          // Completion takes priority over a simultaneous timeout.
          if (bus.cpu_ready) begin
            dout_q  <= bus.cpu_data_out;
            err_q   <= 1'b0;
            state_q <= DONE;
          end else if (timeout_hit) begin
            dout_q      <= 8'h00;
            err_q       <= 1'b1;
            rec_first_q <= 1'b1;
            state_q     <= RECOVER;
          end
        end
        RECOVER: begin
          rec_first_q <= 1'b0;
          if (bus.cpu_ready) begin
            state_q <= DONE;
          end
        end
        DONE: begin
          state_q <= IDLE;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  // Outputs are pure decodes of registers, so reset clears them at once.
  assign bus.state_out   = state_q;
  assign bus.busy        = (state_q != IDLE);
  assign bus.cpu_start   = (state_q == LAUNCH);
  assign bus.cpu_reset   = rec_first_q;
  assign bus.cpu_data_in = data_in_q;
  assign bus.ack0        = (state_q == DONE) && !grant_q;
  assign bus.ack1        = (state_q == DONE) &&  grant_q;
  assign bus.dout        = dout_q;
  assign bus.err         = err_q;

endmodule

// File: tb/tb_yasac_host_arbiter.sv
module tb_yasac_host_arbiter;

  localparam int TO = 16;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  yasac_host_arbiter_if bus ();

  yasac_host_arbiter #(.TIMEOUT(TO), .CNT_W(8)) dut (
    .clk   (clk),
    .reset (rst),
    .bus   (bus)
  );

  // Processor model: mode 0 normal (ready back 5 cycles after start),
  // mode 1 drops ready and hangs, mode 2 never drops ready.
  int         mode = 0;
  logic       model_ready;
  logic [7:0] model_out;
  int         model_cnt;

  always @(posedge clk) begin
    if (rst || bus.cpu_reset) begin
      model_ready <= 1'b1;
      model_cnt   <= 0;
      if (rst) model_out <= 8'h00;
    end else if (model_ready && bus.cpu_start && mode != 2) begin
      model_ready <= 1'b0;
      model_cnt   <= 4;
    end else if (!model_ready && mode != 1) begin
      if (model_cnt <= 1) begin
        model_ready <= 1'b1;
        model_out   <= bus.cpu_data_in + 8'h2B;
      end else begin
        model_cnt <= model_cnt - 1;
      end
    end
  end

  assign bus.cpu_ready    = model_ready;
  assign bus.cpu_data_out = model_out;

  function automatic logic [7:0] calc(input logic [7:0] d);
    return d + 8'h2B;
  endfunction

  int checks = 0;
  int errors = 0;

  task automatic check_val(input string tag, input logic [31:0] got,
                           input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  typedef struct packed {
    logic       id;
    logic [7:0] din;
    logic [7:0] dout;
    logic       err;
  } exp_t;

  exp_t sb[$];

  task automatic push(input logic id, input logic [7:0] din,
                      input logic [7:0] dout, input logic err);
    exp_t e;
    e.id = id; e.din = din; e.dout = dout; e.err = err;
    sb.push_back(e);
  endtask

  // Monitor: samples on the falling edge.
  int   cyc = 0;
  int   start_cyc = 0;
  int   rise_cyc = 0;
  int   n_start = 0;
  int   acks = 0;
  logic prev_start = 1'b0;
  logic prev_ready = 1'b1;
  logic prev_creset = 1'b0;

  always @(negedge clk) begin
    exp_t e;
    cyc++;
    if (bus.cpu_start) begin
      n_start++;
      start_cyc = cyc;
      check_val("start_width", prev_start, 0);
      if (sb.size() > 0) check_val("start_din", bus.cpu_data_in, sb[0].din);
      else               check_val("unexpected_start", 1, 0);
    end
    if (bus.cpu_ready && !prev_ready) rise_cyc = cyc;
    if (bus.cpu_reset) begin
      check_val("cpu_reset_delay", cyc - start_cyc, TO);
      check_val("cpu_reset_width", prev_creset, 0);
    end
    if (bus.ack0 || bus.ack1) begin
      acks++;
      if (sb.size() == 0) begin
        check_val("unexpected_ack", 1, 0);
      end else begin
        e = sb.pop_front();
        check_val("ack_id", {bus.ack1, bus.ack0}, e.id ? 2 : 1);
        check_val("ack_dout", bus.dout, e.dout);
        check_val("ack_err", bus.err, e.err);
        check_val("held_din", bus.cpu_data_in, e.din);
        $display("ack%0d dout=%02h err=%0d cycle=%0d", e.id, bus.dout, bus.err, cyc);
        if (!e.err) check_val("ack_latency", cyc - rise_cyc, 1);
      end
    end
    prev_start  = bus.cpu_start;
    prev_ready  = bus.cpu_ready;
    prev_creset = bus.cpu_reset;
  end

  task automatic wait_acks(input int n);
    int target;
    int t;
    target = acks + n;
    t = 0;
    while (acks < target && t < 300) begin
      @(negedge clk);
      #1;
      t++;
    end
    check_val("ack_wait", acks, target);
  endtask

  task automatic apply_reset();
    @(negedge clk);
    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    #1;
    rst = 1'b0;
  endtask

  initial begin
    int t;
    bus.req0 = 1'b0; bus.req1 = 1'b0;
    bus.din0 = 8'h00; bus.din1 = 8'h00;
    repeat (2) @(posedge clk);
    @(negedge clk);
    #1;
    check_val("rst_state", bus.state_out, 0);
    check_val("rst_busy", bus.busy, 0);
    check_val("rst_start", bus.cpu_start, 0);
    check_val("rst_cpu_reset", bus.cpu_reset, 0);
    check_val("rst_acks", {bus.ack1, bus.ack0}, 0);
    check_val("rst_din", bus.cpu_data_in, 0);
    check_val("rst_dout", bus.dout, 0);
    check_val("rst_err", bus.err, 0);
    rst = 1'b0;

    // Single request from requester 0.
    n_start = 0;
    push(1'b0, 8'h2A, 8'h55, 1'b0);
    bus.din0 = 8'h2A; bus.req0 = 1'b1;
    wait_acks(1);
    bus.req0 = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    check_val("t1_start_count", n_start, 1);

    // Both held from reset: alternate 0,1,0,1.
    apply_reset();
    bus.din0 = 8'h11; bus.din1 = 8'h22;
    for (int i = 0; i < 4; i++) begin
      if (i % 2 == 0) push(1'b0, 8'h11, calc(8'h11), 1'b0);
      else            push(1'b1, 8'h22, calc(8'h22), 1'b0);
    end
    bus.req0 = 1'b1; bus.req1 = 1'b1;
    wait_acks(4);
    bus.req0 = 1'b0; bus.req1 = 1'b0;

    // Processor hangs with ready low.
    mode = 1;
    push(1'b1, 8'h33, 8'h00, 1'b1);
    bus.din1 = 8'h33; bus.req1 = 1'b1;
    wait_acks(1);
    bus.req1 = 1'b0;
    mode = 0;

    // Processor never drops ready.
    mode = 2;
    push(1'b0, 8'h44, 8'h00, 1'b1);
    bus.din0 = 8'h44; bus.req0 = 1'b1;
    wait_acks(1);
    bus.req0 = 1'b0;
    mode = 0;

    // Normal operation after recovery.
    push(1'b1, 8'h7F, calc(8'h7F), 1'b0);
    bus.din1 = 8'h7F; bus.req1 = 1'b1;
    wait_acks(1);
    bus.req1 = 1'b0;

    // Reset during RUN.
    push(1'b0, 8'h5A, calc(8'h5A), 1'b0);
    bus.din0 = 8'h5A; bus.req0 = 1'b1;
    t = 0;
    while (bus.state_out != 3'd3 && t < 50) begin
      @(negedge clk);
      #1;
      t++;
    end
    check_val("reach_run", bus.state_out, 3);
    bus.req0 = 1'b0;
    rst = 1'b1;
    #1;
    check_val("mid_rst_state", bus.state_out, 0);
    check_val("mid_rst_busy", bus.busy, 0);
    check_val("mid_rst_start", bus.cpu_start, 0);
    check_val("mid_rst_acks", {bus.ack1, bus.ack0}, 0);
    sb.delete();
    repeat (2) @(posedge clk);
    @(negedge clk);
    #1;
    rst = 1'b0;
    push(1'b0, 8'h11, calc(8'h11), 1'b0);
    push(1'b1, 8'h22, calc(8'h22), 1'b0);
    bus.din0 = 8'h11; bus.din1 = 8'h22;
    bus.req0 = 1'b1; bus.req1 = 1'b1;
    wait_acks(2);
    bus.req0 = 1'b0; bus.req1 = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    check_val("sb_empty", sb.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
